mine_placer: RTL and testbench

// - Pseudo-random mine placement stage directly upstream of the game datapath.
// - On start, draws N_MINES distinct cell indices on the 5x5 board (cells 0..24) using a 16-bit LFSR.
// - Presents the result on a one-hot board mask, `mines`, which the datapath latches during its start phase.
// - Rejection sampling: out-of-range and duplicate candidates are discarded and redrawn.

---
 rtl/mine_placer.sv | 108 ++++++++++
 tb/tb_mine_placer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_placer.sv
// mine_placer: draws N_MINES distinct cells of a 5x5 board by LFSR rejection sampling. Optional macro: SAFE_FIRST_EN.
// Latency: DRAW is entered on the edge after start; at least N_MINES+1 edges from start to place_done.
// Backpressure: none; start and seed_load are ignored while busy, and only reset aborts a placement.
module mine_placer #(
  parameter int          N_CELLS  = 25,
  parameter int          N_MINES  = 5,
  parameter logic [15:0] SEED_RST = 16'hACE1
) (
  input  logic               clka,
  input  logic               restart_n,
  input  logic               start,
  input  logic               seed_load,
  input  logic [15:0]        seed,
  input  logic [4:0]         safe_cell,
  output logic [N_CELLS-1:0] mines,
  output logic               busy,
  output logic               place_done
);

  localparam int CW = $clog2(N_CELLS + 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [CW-1:0] count;

  logic [4:0]    cand;
  logic          fb;
  logic          in_range;
  logic          is_dup;
  logic          is_safe;
  logic          accept;
  logic          last_mine;
  logic [31:0]   mines_pad;
  logic [31:0]   cand_onehot;

  // Candidate is the low five LFSR bits; the mask is padded to 32 so any 5-bit index is legal.
  assign cand        = lfsr[4:0];
  assign fb          = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign mines_pad   = 32'(mines);
  assign cand_onehot = 32'd1 << cand;
  assign in_range    = (32'(cand) < N_CELLS);
  assign is_dup      = mines_pad[cand];

`ifdef SAFE_FIRST_EN
  // An out-of-range safe_cell can only match candidates that are already rejected.
  assign is_safe = (cand == safe_cell);
`else
  logic unused_safe_cell;
  assign unused_safe_cell = ^safe_cell;
  assign is_safe          = 1'b0;
`endif

  assign accept    = in_range && !is_dup && !is_safe;
  assign last_mine = (count == CW'(N_MINES - 1));

  // LFSR free-runs in every state; a seed load outside DRAW replaces the shift for that cycle.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      lfsr <= SEED_RST;
    end else if (seed_load && (state != DRAW)) begin
      lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      lfsr <= {lfsr[14:0], fb};
    end
  end

  // Placement FSM with registered mask, count and status outputs.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state      <= IDLE;
      mines      <= '0;
      count      <= '0;
      busy       <= 1'b0;
      place_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRAW;
            mines      <= '0;
            count      <= '0;
            busy       <= 1'b1;
            place_done <= 1'b0;
          end
        end
        DRAW: begin
          if (accept) begin
            mines <= mines | cand_onehot[N_CELLS-1:0];
            count <= count + CW'(1);
            if (last_mine) begin
              state      <= DONE;
              busy       <= 1'b0;
              place_done <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          place_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: random and directed placements against a cell-list reference model.
// Two instances share stimulus: the default 5-mine board and a nearly full board.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mine_placer;

  localparam int          NC   = 25;
  localparam int          NM   = 5;
  localparam logic [15:0] SRST = 16'hACE1;
`ifdef SAFE_FIRST_EN
  localparam int NB   = 23;
  localparam bit SAFE = 1'b1;
`else
  localparam int NB   = 24;
  localparam bit SAFE = 1'b0;
`endif

  logic        clka = 1'b0;
  logic        restart_n;
  logic        start;
  logic        seed_load;
  logic [15:0] seed;
  logic [4:0]  safe_cell;
  logic [24:0] mines;
  logic [24:0] mines_b;
  logic        busy, busy_b;
  logic        place_done, place_done_b;

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] m_lfsr;
  bit          m_draw;

  always #5 clka = ~clka;

  mine_placer #(.N_CELLS(NC), .N_MINES(NM), .SEED_RST(SRST)) dut (
    .clka(clka), .restart_n(restart_n), .start(start), .seed_load(seed_load),
    .seed(seed), .safe_cell(safe_cell), .mines(mines), .busy(busy),
    .place_done(place_done)
  );

  mine_placer #(.N_CELLS(NC), .N_MINES(NB), .SEED_RST(SRST)) dut_b (
    .clka(clka), .restart_n(restart_n), .start(start), .seed_load(seed_load),
    .seed(seed), .safe_cell(safe_cell), .mines(mines_b), .busy(busy_b),
    .place_done(place_done_b)
  );

  // One step of the x^16+x^14+x^13+x^11+1 sequence: shift left, parity of the taps enters bit 0.
  function automatic logic [15:0] nxt(input logic [15:0] v);
    int par;
    par = v[15] + v[13] + v[12] + v[10];
    return 16'(((32'(v) * 2) % 65536) + (par % 2));
  endfunction

  // Walks the candidate stream from l0, keeping a list of chosen cells until nm are placed.
  function automatic void predict(input logic [15:0] l0, input int nm,
                                  output logic [24:0] mask, output int edges);
    int          cells[$];
    bit          taken[32];
    int          v;
    logic [15:0] l;
    for (int i = 0; i < 32; i++) taken[i] = 1'b0;
    l     = l0;
    edges = 0;
    mask  = '0;
    while (cells.size() < nm && edges < 100000) begin
      v = int'(l) % 32;
      if (v < NC && !taken[v] && !(SAFE && v == int'(safe_cell))) begin
        taken[v] = 1'b1;
        cells.push_back(v);
      end
      edges++;
      l = nxt(l);
    end
    foreach (cells[i]) mask[cells[i]] = 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (!restart_n)                m_lfsr = SRST;
    else if (seed_load && !m_draw) m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
    else                           m_lfsr = nxt(m_lfsr);
    @(posedge clka);
    #1;
  endtask

  task automatic do_reset();
    restart_n = 1'b0;
    m_lfsr    = SRST;
    m_draw    = 1'b0;
    tick();
    tick();
    restart_n = 1'b1;
  endtask

  task automatic load_seed(input logic [15:0] sd);
    seed_load = 1'b1;
    seed      = sd;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic run(input string tag, input bit ld, input logic [15:0] sd,
                     input bit hold, input bit poke,
                     output logic [24:0] got, output int got_edges);
    logic [15:0] l;
    logic [24:0] em, emb, snap;
    int          ee, eeb, n, nd, ndb;
    l = ld ? ((sd == 16'h0) ? 16'h0001 : sd) : nxt(m_lfsr);
    predict(l, NM, em, ee);
    predict(l, NB, emb, eeb);
    start     = 1'b1;
    seed_load = ld;
    seed      = sd;
    tick();
    m_draw    = 1'b1;
    seed_load = 1'b0;
    if (!hold) start = 1'b0;
    check({tag, ":busy"}, 32'(busy), 32'd1);
    check({tag, ":busy_b"}, 32'(busy_b), 32'd1);
    check({tag, ":done_low"}, 32'(place_done), 32'd0);
    check({tag, ":cleared"}, 32'(mines), 32'd0);
    n    = 1;
    nd   = 0;
    ndb  = 0;
    snap = '0;
    while ((nd == 0 || ndb == 0) && n < 4000) begin
      if (poke && n == 2) begin
        seed_load = 1'b1;
        seed      = 16'($urandom);
      end else begin
        seed_load = 1'b0;
      end
      tick();
      n++;
      if (nd == 0 && place_done) begin
        nd    = n;
        start = 1'b0;
        snap  = mines;
      end
      if (ndb == 0 && place_done_b) ndb = n;
    end
    seed_load = 1'b0;
    start     = 1'b0;
    m_draw    = 1'b0;
    check({tag, ":done_edge"}, 32'(nd), 32'(ee + 1));
    check({tag, ":done_edge_b"}, 32'(ndb), 32'(eeb + 1));
    check({tag, ":min_latency"}, 32'(nd >= NM + 1), 32'd1);
    check({tag, ":mask"}, 32'(mines), 32'(em));
    check({tag, ":mask_b"}, 32'(mines_b), 32'(emb));
    check({tag, ":held"}, 32'(mines), 32'(snap));
    check({tag, ":pop"}, 32'($countones(mines)), 32'(NM));
    check({tag, ":pop_b"}, 32'($countones(mines_b)), 32'(NB));
    check({tag, ":busy_end"}, 32'(busy), 32'd0);
    if (SAFE) begin
      check({tag, ":safe"}, 32'(mines[12]), 32'd0);
      check({tag, ":safe_b"}, 32'(mines_b[12]), 32'd0);
    end
    got       = mines;
    got_edges = nd;
  endtask

  initial begin : stim
    logic [24:0] ma, mb, m0, m1;
    logic [24:0] pa, pc;
    int          ea, eb, e0, e1, pe;
    restart_n = 1'b0;
    start     = 1'b0;
    seed_load = 1'b0;
    seed      = 16'h0;
    safe_cell = 5'd12;
    m_lfsr    = SRST;
    m_draw    = 1'b0;
    #3;
    check("rst:mines", 32'(mines), 32'd0);
    check("rst:mines_b", 32'(mines_b), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(place_done), 32'd0);
    tick();
    restart_n = 1'b1;
    tick();
    tick();

    run("basic", 1'b0, 16'h0, 1'b0, 1'b0, ma, ea);

    // Seed 0 must behave exactly like seed 1.
    do_reset();
    load_seed(16'h0000);
    tick();
    run("seed0", 1'b0, 16'h0, 1'b0, 1'b0, m0, e0);
    do_reset();
    load_seed(16'h0001);
    tick();
    run("seed1", 1'b0, 16'h0, 1'b0, 1'b0, m1, e1);
    check("seed0_vs_1:mask", 32'(m1), 32'(m0));
    check("seed0_vs_1:edge", 32'(e1), 32'(e0));

    // Seed loaded in the same cycle as start, restarting from DONE.
    run("s1234a", 1'b1, 16'h1234, 1'b0, 1'b0, ma, ea);
    tick();
    run("s1234b", 1'b1, 16'h1234, 1'b0, 1'b0, mb, eb);
    check("s1234:repeat", 32'(mb), 32'(ma));
    predict(16'h1234, NM, pa, pe);
    predict(16'h4321, NM, pc, pe);
    run("s4321", 1'b1, 16'h4321, 1'b0, 1'b0, mb, eb);
    check("s4321:differs", 32'(mb != ma), 32'(pc != pa));

    // start held through DRAW and a seed_load pulse during DRAW.
    run("hold_poke", 1'b0, 16'h0, 1'b1, 1'b1, mb, eb);

    for (int i = 0; i < 5; i++) begin
      int gap;
      gap = int'($urandom_range(0, 6));
      for (int g = 0; g < gap; g++) tick();
      run($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mb, eb);
    end

    // Reset asserted in the middle of DRAW.
    start = 1'b1;
    tick();
    start  = 1'b0;
    m_draw = 1'b1;
    tick();
    tick();
    check("mid:busy", 32'(busy_b), 32'd1);
    #2;
    restart_n = 1'b0;
    m_lfsr    = SRST;
    m_draw    = 1'b0;
    #1;
    check("mid:mines", 32'(mines), 32'd0);
    check("mid:mines_b", 32'(mines_b), 32'd0);
    check("mid:busy0", 32'(busy), 32'd0);
    check("mid:busy_b0", 32'(busy_b), 32'd0);
    check("mid:done0", 32'(place_done), 32'd0);
    tick();
    restart_n = 1'b1;
    tick();
    run("after_rst", 1'b0, 16'h0, 1'b0, 1'b0, mb, eb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
